// File: rtl/regfile_sb_pkg.sv
// regfile_sb_pkg: shared types and defaults for the register file slice
package regfile_sb_pkg;
  typedef enum logic [1:0] {
    RD_RT   = 2'b00,
    RD_RD   = 2'b01,
    RD_LINK = 2'b10,
    RD_NONE = 2'b11
  } regdst_t;
  localparam int LINK_REG_DEF = 31;
endpackage

// File: rtl/regfile_sb_if.sv
// regfile_sb_if: read, issue and writeback bus of the register file
interface regfile_sb_if #(
  parameter int DATA_W = 32,
  parameter int AW     = 5,
  parameter int NRD    = 2
);
  import regfile_sb_pkg::*;
  logic [NRD-1:0][AW-1:0]     rsel;
  logic [NRD-1:0][DATA_W-1:0] rdat;
  logic [NRD-1:0]             rbusy;
  logic                       iss_v;
  regdst_t                    iss_regdst;
  logic [AW-1:0]              iss_rt;
  logic [AW-1:0]              iss_rd;
  logic [AW-1:0]              iss_wsel;
  logic                       iss_rdy;
  logic                       wb_v;
  logic [AW-1:0]              wb_sel;
  logic [DATA_W-1:0]          wb_dat;
  logic                       err;
  modport master (
    output rsel, iss_v, iss_regdst, iss_rt, iss_rd, wb_v, wb_sel, wb_dat,
    input  rdat, rbusy, iss_wsel, iss_rdy, err
  );
  modport slave (
    input  rsel, iss_v, iss_regdst, iss_rt, iss_rd, wb_v, wb_sel, wb_dat,
    output rdat, rbusy, iss_wsel, iss_rdy, err
  );
endinterface

// File: rtl/regfile_sb_scoreboard.sv
// regfile_sb_scoreboard: per-register pending-write counters with issue/release and sticky error
module regfile_sb_scoreboard #(
  parameter int NREGS = 32,
  parameter int CNT_W = 2,
  localparam int AW   = $clog2(NREGS)
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic                        iss_v,
  input  logic [AW-1:0]               iss_wsel,
  input  logic                        wb_v,
  input  logic [AW-1:0]               wb_sel,
  output logic [NREGS-1:0][CNT_W-1:0] cnt,
  output logic                        iss_rdy,
  output logic                        err
);
  logic [NREGS-1:0][CNT_W-1:0] cnt_nxt;
  logic inc, rel;
  assign iss_rdy = iss_wsel == '0 || cnt[iss_wsel] != '1;
  assign inc     = iss_v && iss_rdy && iss_wsel != '0;
  assign rel     = wb_v && wb_sel != '0;
  // a reservation and a release of the same register in one cycle cancel out
  always_comb begin
    cnt_nxt = cnt;
    for (int r = 1; r < NREGS; r++)
      cnt_nxt[r] = (inc && iss_wsel == AW'(r)) && !(rel && wb_sel == AW'(r)) ? cnt[r] + 1'b1 :
                   (rel && wb_sel == AW'(r)) && !(inc && iss_wsel == AW'(r)) && cnt[r] != '0 ? cnt[r] - 1'b1 :
                   cnt[r];
  end
  // counters and the sticky release-without-reservation flag
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt <= '0;
      err <= 1'b0;
    end else begin
      cnt <= cnt_nxt;
      err <= err || (rel && cnt[wb_sel] == '0);
    end
  end
endmodule

// File: rtl/regfile_sb.sv
// regfile_sb: register file with destination select, writeback bypass and pending-write scoreboard
module regfile_sb
  import regfile_sb_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int NREGS    = 32,
  parameter int NRD      = 2,
  parameter int BYPASS   = 1,
  parameter int LINK_REG = LINK_REG_DEF,
  parameter int CNT_W    = 2
) (
  input logic CLK,
  input logic RST,
  regfile_sb_if.slave bus
);
  localparam int AW = $clog2(NREGS);
  logic [NREGS-1:0][DATA_W-1:0] mem;
  logic [NREGS-1:0][CNT_W-1:0]  cnt;
  logic [AW-1:0]                wsel;
  logic [NRD-1:0]               byp;
  logic                         wb_hit;
  assign wb_hit = bus.wb_v && bus.wb_sel != '0;
  // RegDst decode; "no write" resolves to r0, which is never reserved
  always_comb
    wsel = bus.iss_regdst == RD_RT   ? bus.iss_rt :
           bus.iss_regdst == RD_RD   ? bus.iss_rd :
           bus.iss_regdst == RD_LINK ? AW'(LINK_REG) : '0;
  assign bus.iss_wsel = wsel;
  // data array; r0 is never written so it always reads 0
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) mem <= '0;
    else if (wb_hit) mem[bus.wb_sel] <= bus.wb_dat;
  end
  // per-port bypass; a final outstanding write being retired this cycle no longer counts as busy
  always_comb begin
    byp       = '0;
    bus.rdat  = '0;
    bus.rbusy = '0;
    for (int i = 0; i < NRD; i++) begin
      byp[i]       = BYPASS != 0 && !RST && wb_hit && bus.wb_sel == bus.rsel[i];
      bus.rdat[i]  = byp[i] ? bus.wb_dat : mem[bus.rsel[i]];
      bus.rbusy[i] = cnt[bus.rsel[i]] != '0 && !(byp[i] && cnt[bus.rsel[i]] == CNT_W'(1));
    end
  end
  regfile_sb_scoreboard #(.NREGS(NREGS), .CNT_W(CNT_W)) u_sb (
    .CLK      (CLK),
    .RST      (RST),
    .iss_v    (bus.iss_v),
    .iss_wsel (wsel),
    .wb_v     (bus.wb_v),
    .wb_sel   (bus.wb_sel),
    .cnt      (cnt),
    .iss_rdy  (bus.iss_rdy),
    .err      (bus.err)
  );
endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: directed vector bench for regfile_sb with bypass and no-bypass builds
module tb_regfile_sb;
  import regfile_sb_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  regfile_sb_if #(.DATA_W(32), .AW(5), .NRD(2)) b1 ();
  regfile_sb_if #(.DATA_W(32), .AW(5), .NRD(2)) b0 ();
  regfile_sb #(.BYPASS(1)) u_byp (.CLK(clk), .RST(rst), .bus(b1));
  regfile_sb #(.BYPASS(0)) u_nob (.CLK(clk), .RST(rst), .bus(b0));
  always #5 clk = ~clk;
  typedef struct {
    logic        wv;
    logic [4:0]  ws;
    logic [31:0] wd;
    logic        iv;
    regdst_t     rdt;
    logic [4:0]  rt, rd, s0, s1;
    logic [31:0] e0, e1;
    logic [1:0]  eb;
    logic [4:0]  ew;
    logic        er, ee;
  } vec_t;
  vec_t tv[27];
  function automatic vec_t mk(logic wv, logic [4:0] ws, logic [31:0] wd, logic iv, regdst_t rdt,
                              logic [4:0] rt, logic [4:0] rd, logic [4:0] s0, logic [4:0] s1,
                              logic [31:0] e0, logic [31:0] e1, logic [1:0] eb, logic [4:0] ew,
                              logic er, logic ee);
    vec_t v;
    v.wv = wv; v.ws = ws; v.wd = wd; v.iv = iv; v.rdt = rdt; v.rt = rt; v.rd = rd;
    v.s0 = s0; v.s1 = s1; v.e0 = e0; v.e1 = e1; v.eb = eb; v.ew = ew; v.er = er; v.ee = ee;
    return v;
  endfunction
  task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  initial begin
    tv[0]  = mk(0, 0,  0,     0, RD_NONE, 0, 0, 0,  5,  0,     0,     2'b00, 0,  1, 0);
    tv[1]  = mk(0, 0,  0,     1, RD_RT,   5, 0, 5,  5,  0,     0,     2'b00, 5,  1, 0);
    tv[2]  = mk(1, 5,  'hDEAD,0, RD_NONE, 0, 0, 5,  0,  'hDEAD,0,     2'b00, 0,  1, 0);
    tv[3]  = mk(0, 0,  0,     0, RD_NONE, 0, 0, 5,  0,  'hDEAD,0,     2'b00, 0,  1, 0);
    tv[4]  = mk(0, 0,  0,     1, RD_RD,   3, 7, 7,  3,  0,     0,     2'b00, 7,  1, 0);
    tv[5]  = mk(0, 0,  0,     0, RD_NONE, 0, 0, 7,  3,  0,     0,     2'b01, 0,  1, 0);
    tv[6]  = mk(0, 0,  0,     0, RD_NONE, 0, 0, 7,  3,  0,     0,     2'b01, 0,  1, 0);
    tv[7]  = mk(1, 7,  'h1234,0, RD_NONE, 0, 0, 7,  7,  'h1234,'h1234,2'b00, 0,  1, 0);
    tv[8]  = mk(0, 0,  0,     0, RD_NONE, 0, 0, 7,  5,  'h1234,'hDEAD,2'b00, 0,  1, 0);
    tv[9]  = mk(0, 0,  0,     1, RD_LINK, 0, 0, 31, 0,  0,     0,     2'b00, 31, 1, 0);
    tv[10] = mk(0, 0,  0,     1, RD_LINK, 0, 0, 31, 0,  0,     0,     2'b01, 31, 1, 0);
    tv[11] = mk(0, 0,  0,     1, RD_LINK, 0, 0, 31, 0,  0,     0,     2'b01, 31, 1, 0);
    tv[12] = mk(0, 0,  0,     1, RD_LINK, 0, 0, 31, 0,  0,     0,     2'b01, 31, 0, 0);
    tv[13] = mk(0, 0,  0,     1, RD_LINK, 0, 0, 31, 0,  0,     0,     2'b01, 31, 0, 0);
    tv[14] = mk(1, 31, 1,     0, RD_NONE, 0, 0, 31, 0,  1,     0,     2'b01, 0,  1, 0);
    tv[15] = mk(1, 31, 2,     0, RD_NONE, 0, 0, 31, 31, 2,     2,     2'b11, 0,  1, 0);
    tv[16] = mk(1, 31, 3,     0, RD_NONE, 0, 0, 31, 0,  3,     0,     2'b00, 0,  1, 0);
    tv[17] = mk(0, 0,  0,     0, RD_LINK, 0, 0, 31, 0,  3,     0,     2'b00, 31, 1, 0);
    tv[18] = mk(0, 0,  0,     1, RD_RT,   9, 0, 9,  0,  0,     0,     2'b00, 9,  1, 0);
    tv[19] = mk(1, 9,  'h99,  1, RD_RT,   9, 0, 9,  0,  'h99,  0,     2'b00, 9,  1, 0);
    tv[20] = mk(0, 0,  0,     0, RD_NONE, 0, 0, 9,  9,  'h99,  'h99,  2'b11, 0,  1, 0);
    tv[21] = mk(1, 9,  'h98,  0, RD_NONE, 0, 0, 9,  9,  'h98,  'h98,  2'b00, 0,  1, 0);
    tv[22] = mk(1, 4,  'hFF,  0, RD_NONE, 0, 0, 4,  9,  'hFF,  'h98,  2'b00, 0,  1, 0);
    tv[23] = mk(0, 0,  0,     0, RD_NONE, 0, 0, 4,  0,  'hFF,  0,     2'b00, 0,  1, 1);
    tv[24] = mk(1, 0,  'h55,  0, RD_NONE, 0, 0, 0,  4,  0,     'hFF,  2'b00, 0,  1, 1);
    tv[25] = mk(0, 0,  0,     1, RD_RT,   0, 0, 0,  0,  0,     0,     2'b00, 0,  1, 1);
    tv[26] = mk(0, 0,  0,     0, RD_NONE, 0, 0, 0,  4,  0,     'hFF,  2'b00, 0,  1, 1);
    {b1.wb_v, b1.wb_sel, b1.wb_dat, b1.iss_v, b1.iss_rt, b1.iss_rd, b1.rsel} = '0;
    {b0.wb_v, b0.wb_sel, b0.wb_dat, b0.iss_v, b0.iss_rt, b0.iss_rd, b0.rsel} = '0;
    b1.iss_regdst = RD_NONE;
    b0.iss_regdst = RD_NONE;
    #12 rst = 1'b0;
    for (int i = 0; i < 27; i++) begin
      b1.wb_v = tv[i].wv; b1.wb_sel = tv[i].ws; b1.wb_dat = tv[i].wd;
      b1.iss_v = tv[i].iv; b1.iss_regdst = tv[i].rdt; b1.iss_rt = tv[i].rt; b1.iss_rd = tv[i].rd;
      b1.rsel[0] = tv[i].s0; b1.rsel[1] = tv[i].s1;
      #1;
      chk($sformatf("v%0d rdat0", i), b1.rdat[0], tv[i].e0);
      chk($sformatf("v%0d rdat1", i), b1.rdat[1], tv[i].e1);
      chk($sformatf("v%0d rbusy", i), 32'(b1.rbusy), 32'(tv[i].eb));
      chk($sformatf("v%0d iss_wsel", i), 32'(b1.iss_wsel), 32'(tv[i].ew));
      chk($sformatf("v%0d iss_rdy", i), 32'(b1.iss_rdy), 32'(tv[i].er));
      chk($sformatf("v%0d err", i), 32'(b1.err), 32'(tv[i].ee));
      tick();
    end
    b1.wb_v = 0; b1.iss_v = 1; b1.iss_regdst = RD_RT; b1.iss_rt = 5; b1.rsel[0] = 5;
    tick();
    b1.iss_v = 0; b1.iss_regdst = RD_NONE;
    #1;
    chk("pre-reset rbusy r5", 32'(b1.rbusy[0]), 1);
    chk("pre-reset rdat r5", b1.rdat[0], 'hDEAD);
    b1.wb_v = 1; b1.wb_sel = 5; b1.wb_dat = 'h77;
    rst = 1'b1;
    #1;
    chk("async reset rdat r5", b1.rdat[0], 0);
    chk("async reset rbusy", 32'(b1.rbusy), 0);
    chk("async reset err", 32'(b1.err), 0);
    chk("async reset iss_rdy", 32'(b1.iss_rdy), 1);
    b1.wb_v = 0;
    tick();
    rst = 1'b0;
    #1;
    chk("post-reset rdat r5", b1.rdat[0], 0);
    b0.iss_v = 1; b0.iss_regdst = RD_RT; b0.iss_rt = 3; b0.rsel[0] = 3;
    tick();
    b0.iss_v = 0; b0.iss_regdst = RD_NONE; b0.wb_v = 1; b0.wb_sel = 3; b0.wb_dat = 'h11;
    #1;
    chk("nobyp rdat old", b0.rdat[0], 0);
    chk("nobyp rbusy held", 32'(b0.rbusy[0]), 1);
    tick();
    b0.wb_dat = 'hAA;
    #1;
    chk("nobyp rdat 11", b0.rdat[0], 'h11);
    chk("nobyp rbusy clear", 32'(b0.rbusy[0]), 0);
    tick();
    b0.wb_v = 0;
    #1;
    chk("nobyp rdat AA", b0.rdat[0], 'hAA);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
